pixel_command_engine: RTL and testbench
=======================================

Name: pixel_command_engine

Overview:
Byte-stream command processor that sits between the UART receiver and the framebuffer write port. It is the parametrised successor of the one-byte-per-pixel instruction engine. It parses opcode plus argument bytes and generates framebuffer writes autonomously: full fill, packed full-frame stream, clipped rectangle fill and single pixel. Framebuffer geometry and pixel width are parameters, and malformed or stalled commands are detected and reported.

Parameters:
BITS_PER_PIXEL, 4, pixel width; legal values 1, 2, 4, 8.
FB_WIDTH, 640, pixels per row; must be at most 65535.
FB_HEIGHT, 480, rows; must be at most 65535.
ADDR_WIDTH, 19, write address width; must be at least clog2(FB_WIDTH*FB_HEIGHT).
TIMEOUT_CYCLES, 1000000, maximum idle clocks between argument/stream bytes before the command is aborted.

Ports:
i_Clock  in  1  system clock
i_Reset_n  in  1  asynchronous active-low reset
i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte is valid
i_Rx_Byte  in  8  received byte
o_Write_Enable  out  1  framebuffer write strobe
o_Write_Addr  out  ADDR_WIDTH  linear address, y*FB_WIDTH+x
o_Write_Data  out  BITS_PER_PIXEL  pixel value
o_Busy  out  1  high in every state except IDLE
o_Overrun  out  1  one-cycle pulse: a byte was dropped
o_Error  out  1  one-cycle pulse: unknown opcode or timeout

Behaviour:
- Clock and reset: all outputs are registered. The clock is i_Clock; the reset is i_Reset_n, asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, all counters 0. Reset asserted mid-command aborts immediately; no further writes are issued.
- PPB (pixels per byte) = 8/BITS_PER_PIXEL. A colour byte uses bits [BITS_PER_PIXEL-1:0].
- Multi-byte arguments: 16-bit, little-endian.
- Opcodes:
  - 0x00 NOP: no arguments.
  - 0x01 FILL: 1 argument (colour).
  - 0x02 FRAME: followed by ceil(FB_WIDTH*FB_HEIGHT/PPB) data bytes.
  - 0x03 RECT: 9 arguments in order x, y, w, h (16-bit each), then colour.
  - 0x04 PIXEL: 5 arguments in order x, y (16-bit each), then colour.
  - Any other opcode: o_Error pulses and the state stays IDLE.
- States:
  - IDLE -> ARGS when the opcode has arguments. NOP stays in IDLE.
  - ARGS -> FILL, STREAM, RECT or IDLE after the last argument. PIXEL issues a single write and goes to IDLE.
  - FILL, RECT, STREAM -> IDLE when their last write is issued.
- Latency: the first write is asserted on the 2nd clock after the i_Rx_DV cycle that carried the final argument byte. After that, one write per clock.
- FILL: writes addresses 0 .. FB_WIDTH*FB_HEIGHT-1 in order. o_Write_Enable stays high for exactly FB_WIDTH*FB_HEIGHT cycles.
- RECT and PIXEL clipping:
  - x >= FB_WIDTH, y >= FB_HEIGHT, w == 0 or h == 0: no writes; return to IDLE.
  - Otherwise effective width = min(w, FB_WIDTH-x) and effective height = min(h, FB_HEIGHT-y).
  - Scan is row-major.
  - Row base advances by adding FB_WIDTH; no multiplier in the scan loop. One multiply, y*FB_WIDTH, is permitted once per command and may be pipelined by at most 1 extra cycle; that cycle is included in the latency above.
- STREAM:
  - Each accepted byte is unpacked LSB-first into PPB pixels, one write per clock, at sequential addresses.
  - Pixels beyond the last address (partial final byte) are discarded.
  - A byte arriving while the previous byte is still unpacking is dropped and o_Overrun pulses.
- Bytes arriving in FILL or RECT are dropped and o_Overrun pulses. The command is not aborted.
- Timeout:
  - In ARGS and STREAM, a counter resets on every accepted byte.
  - Reaching TIMEOUT_CYCLES pulses o_Error, discards the partial command and returns to IDLE.
  - FILL and RECT never time out.
- Simultaneous events: an i_Rx_DV in the same cycle as the final write of FILL or RECT is dropped (o_Overrun pulses); the engine returns to IDLE. An opcode is accepted only while in IDLE.
- Address arithmetic: ADDR_WIDTH bits, no wrap. Internal x/y counters are 16 bits.

Decomposition:
- Shared package pixel_cmd_pkg: opcode constants, state encoding, per-opcode argument-count constants.
- One sub-module: pixel_unpacker (byte in, PPB pixels out with a valid/busy handshake), used by STREAM.
- Parser and scan generator stay in the top module.

Test Plan:
- FILL: bench params FB_WIDTH=8, FB_HEIGHT=4. Send 0x01, 0x05 -> 32 consecutive writes, addresses 0..31, data 0x5; o_Busy then drops.
- RECT clip: send 0x03, x=6, y=2, w=5, h=5, colour 0x3 -> writes only at 22, 23, 30, 31, each with data 0x3.
- STREAM: BITS_PER_PIXEL=4, 8x4 buffer. Send 0x02 then bytes 0x21, 0x43, ... (16 bytes, one per 10 clocks) -> pixel 0=1, pixel 1=2, pixel 2=3, ..., addresses sequential, 32 writes total.
- Overrun: during a FILL of the 8x4 buffer, strobe one byte -> single o_Overrun pulse; the fill still completes with 32 writes.
- Timeout and error: with TIMEOUT_CYCLES=50, send 0x04 then 2 bytes and stop -> o_Error at cycle 50 and no write. Then send 0x07 -> o_Error pulse and the state stays IDLE.
- Reset: assert i_Reset_n low mid-FILL -> o_Write_Enable 0 immediately. After release, 0x04, x=1, y=1, colour 0xF -> single write at address 9 with data 0xF.

Source files
------------

// File: rtl/pixel_cmd_pkg.sv
// Shared definitions for the pixel command engine: opcodes, FSM states and
// how many argument bytes each opcode carries.
package pixel_cmd_pkg;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_FILL  = 8'h01;
    localparam logic [7:0] OP_FRAME = 8'h02;
    localparam logic [7:0] OP_RECT  = 8'h03;
    localparam logic [7:0] OP_PIXEL = 8'h04;

    localparam logic [3:0] ARGS_FILL  = 4'd1;
    localparam logic [3:0] ARGS_RECT  = 4'd9;
    localparam logic [3:0] ARGS_PIXEL = 4'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARGS,
        S_SETUP,
        S_FILL,
        S_RECT,
        S_STREAM
    } state_e;

    function automatic logic [3:0] arg_count(input logic [7:0] op);
        case (op)
            OP_FILL:  return ARGS_FILL;
            OP_RECT:  return ARGS_RECT;
            OP_PIXEL: return ARGS_PIXEL;
            default:  return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/pixel_command_engine_pixel_unpacker.sv
// Splits one received byte into 8/BITS_PER_PIXEL pixels, LSB first, one per clock.
module pixel_unpacker #(
    parameter int BITS_PER_PIXEL = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      load_i,
    input  logic [7:0]                byte_i,
    output logic                      pix_vld_o,
    output logic [BITS_PER_PIXEL-1:0] pix_o,
    output logic                      busy_o
);
    localparam int PPB   = 8 / BITS_PER_PIXEL;
    localparam int CNT_W = $clog2(PPB + 1);

    logic [7:0]       shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            shift_d = byte_i;
            cnt_d   = CNT_W'(PPB);
        end else if (cnt_q != '0) begin
            shift_d = shift_q >> BITS_PER_PIXEL;
            cnt_d   = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // A new byte may land in the same cycle the last pixel of the previous one leaves.
    assign pix_vld_o = (cnt_q != '0);
    assign pix_o     = shift_q[BITS_PER_PIXEL-1:0];
    assign busy_o    = (cnt_q > CNT_W'(1));

endmodule

// File: rtl/pixel_command_engine.sv
// Byte-stream command parser and framebuffer write generator (fill, frame
// stream, clipped rectangle, single pixel) with overrun and timeout reporting.
module pixel_command_engine #(
    parameter int BITS_PER_PIXEL = 4,
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int ADDR_WIDTH     = 19,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset_n,
    input  logic                      i_Rx_DV,
    input  logic [7:0]                i_Rx_Byte,
    output logic                      o_Write_Enable,
    output logic [ADDR_WIDTH-1:0]     o_Write_Addr,
    output logic [BITS_PER_PIXEL-1:0] o_Write_Data,
    output logic                      o_Busy,
    output logic                      o_Overrun,
    output logic                      o_Error
);
    import pixel_cmd_pkg::*;

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_WIDTH * FB_HEIGHT - 1);
    localparam logic [15:0] FB_W16 = 16'(FB_WIDTH);
    localparam logic [15:0] FB_H16 = 16'(FB_HEIGHT);

    state_e                    state_q, state_d;
    logic [7:0]                op_q, op_d;
    logic [3:0]                arg_cnt_q, arg_cnt_d;
    logic [71:0]               args_q, args_d;
    logic [TMO_W-1:0]          tmo_q, tmo_d;
    logic [15:0]               x0_q, x0_d, col_q, col_d, row_q, row_d;
    logic [15:0]               effw_q, effw_d, effh_q, effh_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d, saddr_q, saddr_d, addr_q, addr_d;
    logic [BITS_PER_PIXEL-1:0] colour_q, colour_d, data_q, data_d;
    logic                      we_q, we_d, ovr_q, ovr_d, err_q, err_d, busy_q;

    logic [15:0]               sx, sy, sw, sh, ew, eh;
    logic [BITS_PER_PIXEL-1:0] scol;
    logic [ADDR_WIDTH-1:0]     sbase;
    logic                      clip_empty;
    logic                      unp_load, unp_vld, unp_busy, accepted;
    logic [BITS_PER_PIXEL-1:0] unp_pix;
    logic                      unused_args;

    assign unused_args = ^args_q;

    pixel_unpacker #(.BITS_PER_PIXEL(BITS_PER_PIXEL)) u_unpacker (
        .clk_i    (i_Clock),
        .rst_ni   (i_Reset_n),
        .clr_i    (state_q != S_STREAM),
        .load_i   (unp_load),
        .byte_i   (i_Rx_Byte),
        .pix_vld_o(unp_vld),
        .pix_o    (unp_pix),
        .busy_o   (unp_busy)
    );

    // FILL and PIXEL are expressed as rectangles so one clipped scanner serves all three.
    always_comb begin
        sx   = args_q[15:0];
        sy   = args_q[31:16];
        sw   = args_q[47:32];
        sh   = args_q[63:48];
        scol = args_q[64 +: BITS_PER_PIXEL];
        if (op_q == OP_FILL) begin
            sx   = '0;
            sy   = '0;
            sw   = FB_W16;
            sh   = FB_H16;
            scol = args_q[0 +: BITS_PER_PIXEL];
        end else if (op_q == OP_PIXEL) begin
            sw   = 16'd1;
            sh   = 16'd1;
            scol = args_q[32 +: BITS_PER_PIXEL];
        end
        clip_empty = (sx >= FB_W16) || (sy >= FB_H16) || (sw == 16'd0) || (sh == 16'd0);
        ew    = (sw < FB_W16 - sx) ? sw : FB_W16 - sx;
        eh    = (sh < FB_H16 - sy) ? sh : FB_H16 - sy;
        sbase = ADDR_WIDTH'(sy) * ADDR_WIDTH'(FB_WIDTH);
    end

    assign accepted = i_Rx_DV && !unp_busy;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_cnt_d = arg_cnt_q;
        args_d    = args_q;
        tmo_d     = tmo_q;
        x0_d      = x0_q;
        col_d     = col_q;
        row_d     = row_q;
        effw_d    = effw_q;
        effh_d    = effh_q;
        base_d    = base_q;
        saddr_d   = saddr_q;
        colour_d  = colour_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        ovr_d     = 1'b0;
        err_d     = 1'b0;
        unp_load  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmo_d     = '0;
                arg_cnt_d = '0;
                if (i_Rx_DV) begin
                    op_d = i_Rx_Byte;
                    case (i_Rx_Byte)
                        OP_NOP: ;
                        OP_FILL, OP_RECT, OP_PIXEL: state_d = S_ARGS;
                        OP_FRAME: begin
                            state_d = S_STREAM;
                            saddr_d = '0;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_ARGS: begin
                if (i_Rx_DV) begin
                    args_d[{arg_cnt_q, 3'b000} +: 8] = i_Rx_Byte;
                    arg_cnt_d = arg_cnt_q + 4'd1;
                    tmo_d     = '0;
                    if (arg_cnt_q == arg_count(op_q) - 4'd1) state_d = S_SETUP;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            // Setup cycle absorbs the single row-base multiply and issues the first write.
            S_SETUP: begin
                ovr_d = i_Rx_DV;
                if (clip_empty) begin
                    state_d = S_IDLE;
                end else begin
                    we_d     = 1'b1;
                    addr_d   = sbase + ADDR_WIDTH'(sx);
                    data_d   = scol;
                    colour_d = scol;
                    x0_d     = sx;
                    effw_d   = ew;
                    effh_d   = eh;
                    base_d   = sbase;
                    if (ew == 16'd1 && eh == 16'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = (op_q == OP_FILL) ? S_FILL : S_RECT;
                        if (ew == 16'd1) begin
                            col_d  = 16'd0;
                            row_d  = 16'd1;
                            base_d = sbase + ADDR_WIDTH'(FB_WIDTH);
                        end else begin
                            col_d = 16'd1;
                            row_d = 16'd0;
                        end
                    end
                end
            end
            S_FILL, S_RECT: begin
                ovr_d  = i_Rx_DV;
                we_d   = 1'b1;
                addr_d = base_q + ADDR_WIDTH'(x0_q) + ADDR_WIDTH'(col_q);
                data_d = colour_q;
                if (col_q == effw_q - 16'd1) begin
                    if (row_q == effh_q - 16'd1) state_d = S_IDLE;
                    col_d  = 16'd0;
                    row_d  = row_q + 16'd1;
                    base_d = base_q + ADDR_WIDTH'(FB_WIDTH);
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            S_STREAM: begin
                ovr_d    = i_Rx_DV && unp_busy;
                unp_load = accepted;
                if (unp_vld) begin
                    we_d    = 1'b1;
                    addr_d  = saddr_q;
                    data_d  = unp_pix;
                    saddr_d = saddr_q + 1'b1;
                    if (saddr_q == LAST_ADDR) state_d = S_IDLE;
                end
                if (accepted) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            arg_cnt_q <= '0;
            args_q    <= '0;
            tmo_q     <= '0;
            x0_q      <= '0;
            col_q     <= '0;
            row_q     <= '0;
            effw_q    <= '0;
            effh_q    <= '0;
            base_q    <= '0;
            saddr_q   <= '0;
            colour_q  <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            ovr_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_cnt_q <= arg_cnt_d;
            args_q    <= args_d;
            tmo_q     <= tmo_d;
            x0_q      <= x0_d;
            col_q     <= col_d;
            row_q     <= row_d;
            effw_q    <= effw_d;
            effh_q    <= effh_d;
            base_q    <= base_d;
            saddr_q   <= saddr_d;
            colour_q  <= colour_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            ovr_q     <= ovr_d;
            err_q     <= err_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    assign o_Write_Enable = we_q;
    assign o_Write_Addr   = addr_q;
    assign o_Write_Data   = data_q;
    assign o_Busy         = busy_q;
    assign o_Overrun      = ovr_q;
    assign o_Error        = err_q;

endmodule

// File: tb/tb_pixel_command_engine.sv
// Scoreboard bench for pixel_command_engine on an 8x4, 4-bit-per-pixel framebuffer.
module tb_pixel_command_engine;

    localparam int BPP = 4;
    localparam int AW  = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          we, busy, ovr, err;
    logic [AW-1:0] waddr;
    logic [BPP-1:0] wdata;

    typedef struct packed {
        logic [AW-1:0]  addr;
        logic [BPP-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  wr_cnt = 0;
    int  ovr_cnt = 0;
    int  err_cnt = 0;
    bit  sb_off = 1'b0;

    pixel_command_engine #(
        .BITS_PER_PIXEL(BPP),
        .FB_WIDTH      (8),
        .FB_HEIGHT     (4),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(50)
    ) dut (
        .i_Clock       (clk),
        .i_Reset_n     (rst_n),
        .i_Rx_DV       (rx_dv),
        .i_Rx_Byte     (rx_byte),
        .o_Write_Enable(we),
        .o_Write_Addr  (waddr),
        .o_Write_Data  (wdata),
        .o_Busy        (busy),
        .o_Overrun     (ovr),
        .o_Error       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (ovr) ovr_cnt++;
            if (err) err_cnt++;
            if (we) begin
                wr_cnt++;
                if (!sb_off) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                                 waddr, wdata);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("wr_addr", int'(waddr), int'(e.addr));
                        chk("wr_data", int'(wdata), int'(e.data));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick(1);
        rx_dv   = 1'b0;
    endtask

    task automatic expect_wr(input int a, input int d);
        wr_t e;
        e.addr = AW'(a);
        e.data = BPP'(d);
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            tick(1);
            n++;
        end
        if (busy || exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle with none pending",
                     name, busy, exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    logic [7:0] stream_bytes [16] = '{8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F,
                                      8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB, 8'hED, 8'h0F};

    initial begin
        int w0, o0, e0, lat;

        tick(3);
        @(negedge clk);
        chk("rst_we", int'(we), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_addr", int'(waddr), 0);
        chk("rst_data", int'(wdata), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // FILL colour 5 over the whole 8x4 buffer
        w0 = wr_cnt;
        for (int a = 0; a < 32; a++) expect_wr(a, 5);
        send(8'h01);
        send(8'h05);
        chk("fill_busy_during", int'(busy), 1);
        wait_done("fill", 100);
        chk("fill_writes", wr_cnt - w0, 32);
        chk("fill_busy_after", int'(busy), 0);

        // RECT x=6 y=2 w=5 h=5 colour 3, clipped to a 2x2 corner
        w0 = wr_cnt;
        expect_wr(22, 3);
        expect_wr(23, 3);
        expect_wr(30, 3);
        expect_wr(31, 3);
        send(8'h03);
        send(8'd6); send(8'd0);
        send(8'd2); send(8'd0);
        send(8'd5); send(8'd0);
        send(8'd5); send(8'd0);
        send(8'h03);
        wait_done("rect", 50);
        chk("rect_writes", wr_cnt - w0, 4);

        // RECT fully outside the buffer: no writes
        w0 = wr_cnt;
        send(8'h03);
        send(8'd8); send(8'd0);
        send(8'd0); send(8'd0);
        send(8'd2); send(8'd0);
        send(8'd2); send(8'd0);
        send(8'h07);
        wait_done("rect_out", 20);
        chk("rect_out_writes", wr_cnt - w0, 0);

        // FRAME stream: pixel i carries (i+1) mod 16
        w0 = wr_cnt;
        o0 = ovr_cnt;
        for (int a = 0; a < 32; a++) expect_wr(a, (a + 1) % 16);
        send(8'h02);
        for (int k = 0; k < 16; k++) begin
            send(stream_bytes[k]);
            tick(9);
        end
        wait_done("stream", 50);
        chk("stream_writes", wr_cnt - w0, 32);
        chk("stream_no_ovr", ovr_cnt - o0, 0);

        // Byte strobed during FILL is dropped with one overrun pulse
        w0 = wr_cnt;
        o0 = ovr_cnt;
        for (int a = 0; a < 32; a++) expect_wr(a, 9);
        send(8'h01);
        send(8'h09);
        tick(5);
        send(8'hAA);
        wait_done("ovr_fill", 100);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_fill_writes", wr_cnt - w0, 32);

        // PIXEL truncated after two argument bytes times out
        w0 = wr_cnt;
        e0 = err_cnt;
        lat = 0;
        send(8'h04);
        send(8'h01);
        send(8'h00);
        for (int i = 1; i <= 200; i++) begin
            tick(1);
            if (err) begin
                lat = i;
                break;
            end
        end
        chk("timeout_latency", lat, 50);
        tick(1);
        chk("timeout_busy", int'(busy), 0);
        chk("timeout_writes", wr_cnt - w0, 0);

        // Unknown opcode
        send(8'h07);
        chk("badop_err", int'(err), 1);
        chk("badop_busy", int'(busy), 0);
        tick(2);
        chk("err_pulses", err_cnt - e0, 2);

        // Reset mid-FILL stops writes at once
        sb_off = 1'b1;
        send(8'h01);
        send(8'h0C);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_we", int'(we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        w0 = wr_cnt;
        tick(3);
        chk("rst_mid_writes", wr_cnt - w0, 0);
        rst_n = 1'b1;
        tick(2);
        sb_off = 1'b0;

        // PIXEL x=1 y=1 colour F after reset
        w0 = wr_cnt;
        expect_wr(9, 15);
        send(8'h04);
        send(8'd1); send(8'd0);
        send(8'd1); send(8'd0);
        send(8'h0F);
        wait_done("pixel", 20);
        chk("pixel_writes", wr_cnt - w0, 1);
        chk("pending_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
